dms_lpf_dt: RTL and testbench

Discrete-time, clocked real-number model of the CDR charge-pump loop filter. It is the parametrised successor of the single-cap filter: order 1 is the cap to ground only; order 2 is that cap in parallel with a series R–C branch. Each clock it integrates charge-pump up/dn current into the node voltages using forward Euler. It adds clamping, hold, direct initial-condition load, run/idle control and a saturation counter. It sits between the phase-detector/charge-pump model and the VCO control input.

---
 rtl/dms_lpf_dt_pkg.sv | 31 +++
 rtl/dms_lpf_node_int.sv | 20 ++
 rtl/dms_lpf_dt.sv | 152 +++++++++++++++
 tb/tb_dms_lpf_dt.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/dms_lpf_dt_pkg.sv
// Shared types, default loop-filter constants and the clamp helper for the
// discrete-time charge-pump loop filter model.
package dms_lpf_dt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    HOLD  = 2'd2
  } lpf_state_e;

  localparam real C1_DEF  = 3e-12;
  localparam real R2_DEF  = 5206.0;
  localparam real C2_DEF  = 36e-12;
  localparam real ICP_DEF = 50e-6;
  localparam real TS_DEF  = 1e-10;

  // Clip v into [lo, hi]; clip reports whether the value was changed.
  function automatic real clamp_r(input real v, input real lo, input real hi,
                                  output logic clip);
    clip    = 1'b0;
    clamp_r = v;
    if (v < lo) begin
      clamp_r = lo;
      clip    = 1'b1;
    end else if (v > hi) begin
      clamp_r = hi;
      clip    = 1'b1;
    end
  endfunction

endpackage

// File: rtl/dms_lpf_node_int.sv
// Single clamped integrator node: v_next = clamp(v + dq/C), with clip flag.
module dms_lpf_node_int
  import dms_lpf_dt_pkg::*;
#(
  parameter real C    = C1_DEF,
  parameter real VMIN = 0.0,
  parameter real VMAX = 1.8
) (
  input  real  v,
  input  real  dq,
  output real  v_next_c,
  output logic clip_c
);

  always_comb begin
    clip_c   = 1'b0;
    v_next_c = clamp_r(v + dq / C, VMIN, VMAX, clip_c);
  end

endmodule

// File: rtl/dms_lpf_dt.sv
// Forward-Euler loop filter (order 1: C1; order 2: C1 || R2-C2) with clamp,
// hold, initial-condition load, run/idle control and a saturation counter.
module dms_lpf_dt
  import dms_lpf_dt_pkg::*;
#(
  parameter int unsigned ORDER = 2,
  parameter real         C1    = C1_DEF,
  parameter real         R2    = R2_DEF,
  parameter real         C2    = C2_DEF,
  parameter real         TS    = TS_DEF,
  parameter real         ICP   = ICP_DEF,
  parameter real         VIC   = 1.5,
  parameter real         VMIN  = 0.0,
  parameter real         VMAX  = 1.8,
  parameter int unsigned CNTW  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            up,
  input  logic            dn,
  input  logic            hold,
  input  logic            load,
  input  real             load_val,
  output real             vctl,
  output real             vmid,
  output logic [1:0]      state,
  output logic            valid,
  output logic            clamped,
  output logic [CNTW-1:0] sat_cnt
);

  localparam logic [CNTW-1:0] SAT_MAX = '1;

  if (!(ORDER == 1 || ORDER == 2)) begin : g_bad_order
    $error("dms_lpf_dt: ORDER must be 1 or 2");
  end
  if (TS >= R2 * C1) begin : g_unstable
    $error("dms_lpf_dt: TS >= R2*C1, forward Euler is unstable");
  end
  if (VMIN >= VMAX) begin : g_bad_clamp
    $error("dms_lpf_dt: VMIN must be below VMAX");
  end

  lpf_state_e st;
  logic       xz_warned;

  logic up_x_c, dn_x_c, up_s_c, dn_s_c;
  real  i_c, ir_c, dq1_c, dq2_c;
  real  v1_next_c, v2_next_c, ld_v_c;
  logic clip1_c, clip2_c, clip_any_c, ld_clip_c;

  // Charge-pump current and zero-branch current from pre-update node voltages.
  always_comb begin
    up_x_c    = $isunknown(up);
    dn_x_c    = $isunknown(dn);
    up_s_c    = up_x_c ? 1'b0 : up;
    dn_s_c    = dn_x_c ? 1'b0 : dn;
    i_c       = 0.0;
    if (up_s_c && !dn_s_c) begin
      i_c = ICP;
    end else if (dn_s_c && !up_s_c) begin
      i_c = -ICP;
    end
    ir_c      = (ORDER == 2) ? (vctl - vmid) / R2 : 0.0;
    dq1_c     = (i_c - ir_c) * TS;
    dq2_c     = ir_c * TS;
    ld_clip_c = 1'b0;
    ld_v_c    = clamp_r(load_val, VMIN, VMAX, ld_clip_c);
  end

  dms_lpf_node_int #(.C(C1), .VMIN(VMIN), .VMAX(VMAX)) u_node_v1 (
    .v        (vctl),
    .dq       (dq1_c),
    .v_next_c (v1_next_c),
    .clip_c   (clip1_c)
  );

  dms_lpf_node_int #(.C(C2), .VMIN(VMIN), .VMAX(VMAX)) u_node_v2 (
    .v        (vmid),
    .dq       (dq2_c),
    .v_next_c (v2_next_c),
    .clip_c   (clip2_c)
  );

  assign clip_any_c = clip1_c | ((ORDER == 2) & clip2_c);
  assign state      = st;

  // Priority: rst > load > !en > hold > update.
  always_ff @(posedge clk) begin
    if (rst) begin
      vctl      <= VIC;
      vmid      <= VIC;
      st        <= IDLE;
      valid     <= 1'b0;
      clamped   <= 1'b0;
      sat_cnt   <= '0;
      xz_warned <= 1'b0;
    end else begin
      if ((up_x_c || dn_x_c) && !xz_warned) begin
        $warning("dms_lpf_dt: X/Z on up/dn treated as 0");
        xz_warned <= 1'b1;
      end
      if (load) begin
        vctl    <= ld_v_c;
        vmid    <= ld_v_c;
        clamped <= ld_clip_c;
        st      <= en ? TRACK : IDLE;
        valid   <= en;
      end else if (!en) begin
        st      <= IDLE;
        valid   <= 1'b0;
        clamped <= 1'b0;
      end else begin
        case (st)
          IDLE: begin
            st      <= TRACK;
            valid   <= 1'b1;
            clamped <= 1'b0;
          end
          TRACK: begin
            if (hold) begin
              st      <= HOLD;
              valid   <= 1'b0;
              clamped <= 1'b0;
            end else begin
              vctl    <= v1_next_c;
              vmid    <= (ORDER == 2) ? v2_next_c : v1_next_c;
              clamped <= clip_any_c;
              if (clip_any_c && sat_cnt != SAT_MAX) begin
                sat_cnt <= sat_cnt + CNTW'(1);
              end
            end
          end
          HOLD: begin
            clamped <= 1'b0;
            if (!hold) begin
              st    <= TRACK;
              valid <= 1'b1;
            end
          end
          default: begin
            st      <= IDLE;
            valid   <= 1'b0;
            clamped <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dms_lpf_dt.sv
// Directed bench for dms_lpf_dt: an ORDER=1 and an ORDER=2 instance on one clock.
module tb_dms_lpf_dt;

  localparam real D1   = 50e-6 * 1e-10 / 3e-12;
  localparam real R2   = 5206.0;
  localparam real TS   = 1e-10;
  localparam real C1   = 3e-12;
  localparam real C2   = 36e-12;
  localparam real TOL  = 1e-9;

  logic        clk = 1'b0;
  logic        rst, en, up, dn, hold, load;
  real         load_val;
  real         vctl, vmid;
  logic [1:0]  state;
  logic        valid, clamped;
  logic [15:0] sat_cnt;

  logic        en2, up2, dn2, hold2, load2;
  real         load_val2;
  real         vctl2, vmid2;
  logic [1:0]  state2;
  logic        valid2, clamped2;
  logic [15:0] sat_cnt2;

  int checks   = 0;
  int failures = 0;

  real ev, v1a, v1b, v2b, ir;

  dms_lpf_dt #(.ORDER(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .up(up), .dn(dn), .hold(hold), .load(load),
    .load_val(load_val), .vctl(vctl), .vmid(vmid), .state(state), .valid(valid),
    .clamped(clamped), .sat_cnt(sat_cnt)
  );

  dms_lpf_dt #(.ORDER(2)) dut2 (
    .clk(clk), .rst(rst), .en(en2), .up(up2), .dn(dn2), .hold(hold2), .load(load2),
    .load_val(load_val2), .vctl(vctl2), .vmid(vmid2), .state(state2), .valid(valid2),
    .clamped(clamped2), .sat_cnt(sat_cnt2)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_r(input string tag, input real got, input real exp);
    real diff;
    diff = (got > exp) ? got - exp : exp - got;
    checks++;
    assert (diff <= TOL) else begin
      failures++;
      $error("FAIL %s observed=%0.10f expected=%0.10f", tag, got, exp);
    end
  endtask

  task automatic chk_i(input string tag, input longint got, input longint exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b0; dn = 1'b0; hold = 1'b0; load = 1'b0;
    load_val = 0.0;
    en2 = 1'b0; up2 = 1'b0; dn2 = 1'b0; hold2 = 1'b0; load2 = 1'b0;
    load_val2 = 0.0;
    step(1);
    rst = 1'b0;
    chk_r("rst_vctl", vctl, 1.5);
    chk_r("rst_vmid", vmid, 1.5);
    chk_i("rst_state", state, 0);
    chk_i("rst_valid", valid, 0);
    chk_i("rst_clamped", clamped, 0);
    chk_i("rst_sat", sat_cnt, 0);
    chk_r("rst_vctl2", vctl2, 1.5);

    // ORDER=2: one up pulse, then one idle update.
    en2 = 1'b1;
    step(1);
    chk_i("o2_state_entry", state2, 1);
    chk_r("o2_entry_noupd", vctl2, 1.5);
    up2 = 1'b1;
    step(1);
    v1a = 1.5 + D1;
    chk_r("o2_e1_vctl", vctl2, v1a);
    chk_r("o2_e1_vmid", vmid2, 1.5);
    up2 = 1'b0;
    step(1);
    ir  = (v1a - 1.5) / R2;
    v1b = v1a - ir * TS / C1;
    v2b = 1.5 + ir * TS / C2;
    chk_r("o2_e2_vctl", vctl2, v1b);
    chk_r("o2_e2_vmid", vmid2, v2b);
    en2 = 1'b0;

    // ORDER=1 up ramp: entry edge, then 10 updates.
    en = 1'b1;
    step(1);
    chk_r("o1_entry_noupd", vctl, 1.5);
    up = 1'b1;
    step(10);
    ev = 1.5 + 10.0 * D1;
    chk_r("o1_ramp_vctl", vctl, ev);
    chk_r("o1_ramp_vmid", vmid, ev);
    chk_i("o1_ramp_state", state, 1);
    chk_i("o1_ramp_valid", valid, 1);

    // Hold freezes the node; release edge re-enters TRACK without updating.
    hold = 1'b1;
    step(5);
    chk_r("hold_vctl", vctl, ev);
    chk_i("hold_state", state, 2);
    chk_i("hold_valid", valid, 0);
    hold = 1'b0;
    step(1);
    chk_i("release_state", state, 1);
    chk_r("release_noupd", vctl, ev);
    step(1);
    ev = ev + D1;
    chk_r("release_resume", vctl, ev);

    up = 1'b0; dn = 1'b1;
    step(2);
    ev = ev - 2.0 * D1;
    chk_r("dn_ramp", vctl, ev);

    up = 1'b1; dn = 1'b1;
    step(20);
    chk_r("updn_const", vctl, ev);
    en = 1'b0; up = 1'b0; dn = 1'b0;
    step(1);
    chk_i("en0_state", state, 0);
    chk_i("en0_valid", valid, 0);
    chk_r("en0_retain", vctl, ev);

    // Load near the rail, then clip and saturate the counter.
    en = 1'b1; load = 1'b1; load_val = 1.799;
    step(1);
    chk_r("load_vctl", vctl, 1.799);
    chk_r("load_vmid", vmid, 1.799);
    chk_i("load_state", state, 1);
    chk_i("load_clamped", clamped, 0);
    load = 1'b0; up = 1'b1;
    step(1);
    chk_r("clip_vctl", vctl, 1.8);
    chk_i("clip_flag", clamped, 1);
    chk_i("clip_sat1", sat_cnt, 1);
    step(70000);
    chk_i("sat_stick", sat_cnt, 65535);
    chk_r("sat_vctl", vctl, 1.8);

    load = 1'b1; load_val = 2.5;
    step(1);
    chk_r("load_clip_vctl", vctl, 1.8);
    chk_i("load_clip_flag", clamped, 1);
    chk_i("load_sat_keep", sat_cnt, 65535);
    load_val = 1.6;
    step(1);
    chk_r("load16_vctl", vctl, 1.6);
    chk_i("load16_clamped", clamped, 0);
    load = 1'b0;
    step(1);
    chk_r("ramp16_vctl", vctl, 1.6 + D1);

    // Mid-ramp reset discards everything.
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk_r("midrst_vctl", vctl, 1.5);
    chk_r("midrst_vmid", vmid, 1.5);
    chk_i("midrst_sat", sat_cnt, 0);
    chk_i("midrst_state", state, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
